prog_clock_divider: RTL and testbench



---
 rtl/prog_clock_divider.sv | 130 +++++++++++++
 tb/tb_prog_clock_divider.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// Run-time programmable clock divider: divides clk by 2*N, square or single-pulse output.
// A shadowed divisor/mode is applied only at a period boundary or while disabled.
module prog_clock_divider #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DIV_DEFAULT  = 2,
  parameter bit          MODE_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             mode_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_rise_q, tick_rise_d;
  logic             tick_fall_q, tick_fall_d;
  logic             div_ack_q, div_ack_d;
  logic             div_err_q, div_err_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] n_act_q, n_act_d;
  logic             mode_act_q, mode_act_d;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  logic             sh_mode_q, sh_mode_d;

  logic             load_ok;
  logic             terminal;
  logic             boundary;
  logic             apply;

  // Next-state: counting, phase/strobe generation and shadow handling.
  always_comb begin
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    clk_out_d   = 1'b0;
    tick_rise_d = 1'b0;
    tick_fall_d = 1'b0;
    div_ack_d   = 1'b0;
    div_err_d   = 1'b0;
    pending_d   = pending_q;
    n_act_d     = n_act_q;
    mode_act_d  = mode_act_q;
    sh_div_d    = sh_div_q;
    sh_mode_d   = sh_mode_q;

    load_ok  = div_load && (div_in != '0);
    terminal = (cnt_q == n_act_q - CNT_W'(1));
    boundary = en && terminal && phase_q;
    apply    = (!en || boundary) && (pending_q || load_ok);

    div_err_d = div_load && (div_in == '0);

    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (terminal) begin
      cnt_d       = '0;
      phase_d     = !phase_q;
      tick_rise_d = !phase_q;
      tick_fall_d = phase_q && !mode_act_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (en) begin
      clk_out_d = mode_act_q ? tick_rise_d : phase_d;
    end

    // A load arriving on the applying edge bypasses the shadow.
    if (apply) begin
      n_act_d    = load_ok ? div_in  : sh_div_q;
      mode_act_d = load_ok ? mode_in : sh_mode_q;
      cnt_d      = '0;
      phase_d    = 1'b0;
      pending_d  = 1'b0;
      div_ack_d  = 1'b1;
    end else if (load_ok) begin
      sh_div_d  = div_in;
      sh_mode_d = mode_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_rise_q <= 1'b0;
      tick_fall_q <= 1'b0;
      div_ack_q   <= 1'b0;
      div_err_q   <= 1'b0;
      pending_q   <= 1'b0;
      n_act_q     <= CNT_W'(DIV_DEFAULT);
      mode_act_q  <= MODE_DEFAULT;
      sh_div_q    <= CNT_W'(DIV_DEFAULT);
      sh_mode_q   <= MODE_DEFAULT;
    end else begin
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      clk_out_q   <= clk_out_d;
      tick_rise_q <= tick_rise_d;
      tick_fall_q <= tick_fall_d;
      div_ack_q   <= div_ack_d;
      div_err_q   <= div_err_d;
      pending_q   <= pending_d;
      n_act_q     <= n_act_d;
      mode_act_q  <= mode_act_d;
      sh_div_q    <= sh_div_d;
      sh_mode_q   <= sh_mode_d;
    end
  end

  assign clk_out   = clk_out_q;
  assign tick_rise = tick_rise_q;
  assign tick_fall = tick_fall_q;
  assign div_ack   = div_ack_q;
  assign div_err   = div_err_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: a position-in-period model predicts every
// registered output per cycle; predictions are queued at drive time and popped after the edge.
module tb_prog_clock_divider;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             mode_in;
  logic             div_load;
  logic             div_ack, div_err, clk_out, tick_rise, tick_fall, pending;

  typedef struct packed {
    logic clk_out;
    logic rise;
    logic fall;
    logic ack;
    logic err;
    logic pend;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // model state: position within the 2N-cycle period
  int m_pos  = 0;
  int m_n    = 2;
  int m_mode = 0;
  int m_sh_n = 2;
  int m_sh_m = 0;
  int m_pend = 0;

  prog_clock_divider #(.CNT_W(CNT_W), .DIV_DEFAULT(2), .MODE_DEFAULT(1'b0)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_in   (div_in),
    .mode_in  (mode_in),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_err  (div_err),
    .clk_out  (clk_out),
    .tick_rise(tick_rise),
    .tick_fall(tick_fall),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, want);
    end
  endtask

  // Drive one cycle of inputs, predict the outputs, advance one edge and compare.
  task automatic step(input bit r, input bit e, input bit ld, input int d, input bit m);
    exp_t x;
    int   pos_n;
    bit   valid, apply;
    reset = r; en = e; div_load = ld; div_in = CNT_W'(d); mode_in = m;
    x = '0;
    if (r) begin
      m_pos = 0; m_n = 2; m_mode = 0; m_pend = 0; m_sh_n = 2; m_sh_m = 0;
    end else begin
      valid = ld && (d != 0);
      x.err = ld && (d == 0);
      if (!e) begin
        m_pos = 0;
        apply = (m_pend != 0) || valid;
      end else begin
        pos_n = (m_pos + 1) % (2 * m_n);
        x.rise = (pos_n == m_n);
        x.fall = (pos_n == 0) && (m_mode == 0);
        x.clk_out = (m_mode != 0) ? x.rise : (pos_n >= m_n);
        apply = (pos_n == 0) && ((m_pend != 0) || valid);
        m_pos = pos_n;
      end
      if (apply) begin
        m_n    = valid ? d : m_sh_n;
        m_mode = valid ? int'(m) : m_sh_m;
        m_pos  = 0;
        m_pend = 0;
        x.ack  = 1'b1;
      end else if (valid) begin
        m_sh_n = d; m_sh_m = int'(m); m_pend = 1;
      end
      x.pend = (m_pend != 0);
    end
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check("clk_out",   int'(clk_out),   int'(x.clk_out));
    check("tick_rise", int'(tick_rise), int'(x.rise));
    check("tick_fall", int'(tick_fall), int'(x.fall));
    check("div_ack",   int'(div_ack),   int'(x.ack));
    check("div_err",   int'(div_err),   int'(x.err));
    check("pending",   int'(pending),   int'(x.pend));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  // idle until the model reports the high phase (bounded)
  task automatic run_to_high();
    for (int i = 0; i < 600 && !(m_mode == 0 && m_pos >= m_n); i++) run(1);
  endtask

  // idle until the next edge will close the period (bounded)
  task automatic run_to_pre_boundary();
    for (int i = 0; i < 600 && ((m_pos + 1) % (2 * m_n)) != 0; i++) run(1);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0; mode_in = 1'b0;

    // 1: reset then default N=2 square
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 9, 1'b1);
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_pending", int'(pending), 0);
    run(16);

    // 2: load N=5 during the high phase
    run_to_high();
    step(1'b0, 1'b1, 1'b1, 5, 1'b0);
    run(32);

    // 3: rejected load of zero
    step(1'b0, 1'b1, 1'b1, 0, 1'b1);
    run(12);

    // 4: two loads in one period, last wins
    run_to_high();
    step(1'b0, 1'b1, 1'b1, 3, 1'b0);
    run(1);
    step(1'b0, 1'b1, 1'b1, 7, 1'b0);
    run(40);

    // 5: pulse mode N=3, then N=1 pulse
    step(1'b0, 1'b1, 1'b1, 3, 1'b1);
    run(30);
    step(1'b0, 1'b1, 1'b1, 1, 1'b1);
    run(12);

    // load landing exactly on the boundary edge, back to square N=1 then N=4
    run_to_pre_boundary();
    step(1'b0, 1'b1, 1'b1, 1, 1'b0);
    run(6);
    run_to_pre_boundary();
    step(1'b0, 1'b1, 1'b1, 4, 1'b0);
    run(12);

    // 6: en drop mid-period with a pending load, then reset mid-run
    run(2);
    step(1'b0, 1'b1, 1'b1, 6, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    run(15);
    step(1'b0, 1'b1, 1'b1, 9, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    check("rst2_clk_out", int'(clk_out), 0);
    check("rst2_pending", int'(pending), 0);
    run(12);

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      int  r = int'($urandom_range(0, 99));
      bit  e = (r >= 4);
      bit  ld = ($urandom_range(0, 19) == 0);
      int  d = int'($urandom_range(0, 6));
      bit  m = 1'($urandom_range(0, 1));
      step(r == 0, e, ld, d, m);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
